// File: rtl/writeback_arbiter.sv
// Shares the regfile write port between writeback and multdiv; WB_STARVE_GUARD_EN enables the starve counter/stall_pipe.
// Port outputs are zero-latency; a colliding multdiv result parks in a one-entry hold buffer and md_ready drops until it drains.
module writeback_arbiter #(
  parameter logic [31:0] MUL_STATUS   = 32'd4,
  parameter logic [31:0] DIV_STATUS   = 32'd5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_reg,
  input  logic [31:0] pipe_data,
  input  logic        md_valid,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  input  logic        md_exception,
  input  logic        md_is_div,
  output logic        md_ready,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        stall_pipe
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state, state_next;
  logic [4:0]  hold_reg;
  logic [31:0] hold_data;
  logic        capture;
  logic        pipe_wr;
  logic [4:0]  md_reg_eff;
  logic [31:0] md_data_eff;
  logic        port_we;
  logic [4:0]  port_reg;
  logic [31:0] port_data;

  assign pipe_wr     = pipe_we && (pipe_reg != 5'd0);
  assign md_reg_eff  = md_exception ? 5'd30 : md_reg;
  assign md_data_eff = md_exception ? (md_is_div ? DIV_STATUS : MUL_STATUS) : md_data;

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    port_we    = 1'b0;
    port_reg   = 5'd0;
    port_data  = 32'd0;
    if (reset) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (pipe_wr) begin
            port_we   = 1'b1;
            port_reg  = pipe_reg;
            port_data = pipe_data;
            // Same destination as the younger pipe write: the md value is dead (WAW).
            if (md_valid && (md_reg_eff != 5'd0) && (md_reg_eff != pipe_reg)) begin
              capture    = 1'b1;
              state_next = HOLD;
            end
          end else if (md_valid && (md_reg_eff != 5'd0)) begin
            port_we   = 1'b1;
            port_reg  = md_reg_eff;
            port_data = md_data_eff;
          end
        end
        HOLD: begin
          if (!pipe_wr) begin
            port_we    = 1'b1;
            port_reg   = hold_reg;
            port_data  = hold_data;
            state_next = IDLE;
          end else begin
            port_we   = 1'b1;
            port_reg  = pipe_reg;
            port_data = pipe_data;
            if (pipe_reg == hold_reg) state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      hold_reg  <= 5'd0;
      hold_data <= 32'd0;
    end else begin
      state <= state_next;
      if (capture) begin
        hold_reg  <= md_reg_eff;
        hold_data <= md_data_eff;
      end else if (state_next == IDLE) begin
        hold_reg  <= 5'd0;
        hold_data <= 32'd0;
      end
    end
  end

  assign md_ready         = (state == IDLE) && !reset;
  assign ctrl_writeEnable = port_we;
  assign ctrl_writeReg    = port_reg;
  assign data_writeReg    = port_data;

`ifdef WB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       blocked;
  logic [3:0] starve_cnt, starve_next;
  logic       stall_q;

  // Blocked means parked result lost the port to a write of a different register.
  assign blocked     = !reset && (state == HOLD) && pipe_wr && (pipe_reg != hold_reg);
  assign starve_next = !blocked ? 4'd0 :
                       (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= 4'd0;
      stall_q    <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      stall_q    <= blocked && (starve_next >= LIMIT);
    end
  end

  assign stall_pipe = stall_q && !reset;
`else
  assign stall_pipe = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed-vector bench for writeback_arbiter; starvation expectations follow WB_STARVE_GUARD_EN.
module tb_writeback_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_reg;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_exception;
  logic        md_is_div;
  logic        md_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        stall_pipe;

  int n_cmp = 0;
  int n_err = 0;

`ifdef WB_STARVE_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  writeback_arbiter dut (
    .clock(clock),
    .reset(reset),
    .pipe_we(pipe_we),
    .pipe_reg(pipe_reg),
    .pipe_data(pipe_data),
    .md_valid(md_valid),
    .md_reg(md_reg),
    .md_data(md_data),
    .md_exception(md_exception),
    .md_is_div(md_is_div),
    .md_ready(md_ready),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .stall_pipe(stall_pipe)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] preg, input logic [31:0] pdat,
                       input logic mv, input logic [4:0] mreg, input logic [31:0] mdat,
                       input logic mexc, input logic mdiv);
    pipe_we = pwe; pipe_reg = preg; pipe_data = pdat;
    md_valid = mv; md_reg = mreg; md_data = mdat;
    md_exception = mexc; md_is_div = mdiv;
    @(negedge clock);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [4:0] rg, input logic [31:0] dat);
    check({tag, ".we"}, {31'd0, ctrl_writeEnable}, {31'd0, we});
    check({tag, ".reg"}, {27'd0, ctrl_writeReg}, {27'd0, rg});
    check({tag, ".data"}, data_writeReg, dat);
  endtask

  task automatic check_ready(input string tag, input logic exp);
    check(tag, {31'd0, md_ready}, {31'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h55, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h55, 1'b0, 1'b0);
    check_port("rst", 1'b0, 5'd0, 32'd0);
    check_ready("rst.ready", 1'b0);
    check("rst.stall", {31'd0, stall_pipe}, 32'd0);
    next_cycle();
    reset = 1'b0;

    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check_port("idle", 1'b0, 5'd0, 32'd0);
    check_ready("idle.ready", 1'b1);
    next_cycle();

    // md alone goes straight to the port
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 1'b0);
    check_port("direct", 1'b1, 5'd7, 32'h1234);
    check_ready("direct.ready", 1'b1);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check_ready("direct.idle", 1'b1);
    check_port("direct.after", 1'b0, 5'd0, 32'd0);
    next_cycle();

    // collision then drain
    drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd5, 32'hB, 1'b0, 1'b0);
    check_port("coll.c0", 1'b1, 5'd3, 32'hA);
    check_ready("coll.c0.ready", 1'b1);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check_port("coll.c1", 1'b1, 5'd5, 32'hB);
    check_ready("coll.c1.ready", 1'b0);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check_port("coll.c2", 1'b0, 5'd0, 32'd0);
    check_ready("coll.c2.ready", 1'b1);
    next_cycle();

    // WAW squash of the parked result
    drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd5, 32'hB, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 5'd5, 32'hC, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check_port("squash.c1", 1'b1, 5'd5, 32'hC);
    check_ready("squash.c1.ready", 1'b0);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check_port("squash.c2", 1'b0, 5'd0, 32'd0);
    check_ready("squash.c2.ready", 1'b1);
    next_cycle();

    // same-cycle WAW: md result discarded, nothing parked
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h77, 1'b0, 1'b0);
    check_port("waw.c0", 1'b1, 5'd9, 32'h99);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check_port("waw.c1", 1'b0, 5'd0, 32'd0);
    check_ready("waw.c1.ready", 1'b1);
    next_cycle();

    // exceptions redirect to r30 with status codes
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hFFFF, 1'b1, 1'b1);
    check_port("exc.div", 1'b1, 5'd30, 32'd5);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hFFFF, 1'b1, 1'b0);
    check_port("exc.mul", 1'b1, 5'd30, 32'd4);
    next_cycle();

    // r0 destinations never write or park
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h42, 1'b0, 1'b0);
    check_port("r0.md", 1'b0, 5'd0, 32'd0);
    next_cycle();
    drive(1'b1, 5'd0, 32'h17, 1'b1, 5'd0, 32'h42, 1'b0, 1'b0);
    check_port("r0.both", 1'b0, 5'd0, 32'd0);
    check_ready("r0.ready", 1'b1);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check_ready("r0.nocapture", 1'b1);
    next_cycle();

    // starvation: park r6, then block with r1 writes
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0);
    next_cycle();
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 5'd1, 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      check_port($sformatf("starve.blk%0d", i), 1'b1, 5'd1, 32'h100 + 32'(i));
      check($sformatf("starve.stall%0d", i), {31'd0, stall_pipe}, {31'd0, (i >= 5) ? GUARD : 1'b0});
      next_cycle();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check_port("starve.drain", 1'b1, 5'd6, 32'h66);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check("starve.fall", {31'd0, stall_pipe}, 32'd0);
    check_ready("starve.ready", 1'b1);
    next_cycle();

    // reset while holding drops the parked result
    drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd5, 32'hDEAD, 1'b0, 1'b0);
    next_cycle();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check_port("rsthold.c1", 1'b0, 5'd0, 32'd0);
    check_ready("rsthold.c1.ready", 1'b0);
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check_port("rsthold.c2", 1'b0, 5'd0, 32'd0);
    check_ready("rsthold.c2.ready", 1'b1);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
